alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 135 +++++++++++++
 tb/tb_alu_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared 32-bit ALU (IDLE -> EXEC -> RESP).
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_ctl,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_ctl,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_zero
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e      state_q, state_d;
  logic        grant0, grant1;
  logic        prio0;
  logic [31:0] a_q, b_q;
  logic [2:0]  ctl_q;
  logic        id_q;
  logic        rsp_valid_q, rsp_id_q, rsp_zero_q;
  logic [31:0] rsp_result_q;
  logic [31:0] alu_res, diff;
  logic        ovf;

`ifdef ALU_ARB_RR_EN
  // Holds the index granted last; reset value 1 lets requester 0 win the first contention.
  logic last_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'b1;
    end else if (grant0 || grant1) begin
      last_q <= grant1;
    end
  end

  assign prio0 = last_q;
`else
  assign prio0 = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    grant0  = 1'b0;
    grant1  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!reset) begin
          grant0 = req0_valid && (prio0 || !req1_valid);
          grant1 = req1_valid && !grant0;
        end
        if (grant0 || grant1) state_d = StExec;
      end
      StExec: state_d = StResp;
      StResp: if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Operands are captured only on the grant cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      ctl_q <= '0;
      id_q  <= 1'b0;
    end else if (grant0) begin
      a_q   <= req0_a;
      b_q   <= req0_b;
      ctl_q <= req0_ctl;
      id_q  <= 1'b0;
    end else if (grant1) begin
      a_q   <= req1_a;
      b_q   <= req1_b;
      ctl_q <= req1_ctl;
      id_q  <= 1'b1;
    end
  end

  always_comb begin
    diff = a_q + ~b_q + 32'd1;
    ovf  = (a_q[31] != b_q[31]) && (diff[31] != a_q[31]);
    case (ctl_q)
      3'b000:  alu_res = a_q + b_q;
      3'b001:  alu_res = diff;
      3'b010:  alu_res = a_q & b_q;
      3'b011:  alu_res = a_q | b_q;
      3'b101:  alu_res = {31'b0, diff[31] ^ ovf};
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_id_q     <= 1'b0;
      rsp_zero_q   <= 1'b1;
    end else if (state_q == StExec) begin
      rsp_valid_q  <= 1'b1;
      rsp_result_q <= alu_res;
      rsp_id_q     <= id_q;
      rsp_zero_q   <= (alu_res == 32'd0);
    end else if (state_q == StResp && rsp_ready) begin
      rsp_valid_q  <= 1'b0;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter; expectations follow ALU_ARB_RR_EN when defined.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, rsp_ready;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_ctl, req1_ctl;
  logic        rsp_valid, rsp_id, rsp_zero;
  logic [31:0] rsp_result;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ctl   (req0_ctl),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ctl   (req1_ctl),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // Driver only: issues one request and returns what the DUT presented.
  task automatic run_op(input bit id, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] ctl, output bit granted, output bit seen,
                        output logic [31:0] res, output bit zero, output bit rid);
    step();
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_ctl = ctl;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_ctl = ctl;
    end
    rsp_ready = 1'b1;
    #1;
    granted = id ? req1_ready : req0_ready;
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 32'hDEADBEEF; req1_a = 32'hDEADBEEF;
    seen = 1'b0; res = '0; zero = 1'b0; rid = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      if (rsp_valid) begin
        seen = 1'b1; res = rsp_result; zero = rsp_zero; rid = rsp_id;
      end else begin
        step();
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b0;
    req0_a = 0; req0_b = 0; req0_ctl = 0; req1_a = 0; req1_b = 0; req1_ctl = 0;
    step();
    total++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      bad++; $display("FAIL reset_ready got=%b%b want=00", req0_ready, req1_ready);
    end
    total++;
    if ({rsp_valid, rsp_result, rsp_id, rsp_zero} !== {1'b0, 32'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_rsp got v=%b r=%h id=%b z=%b want v=0 r=0 id=0 z=1",
               rsp_valid, rsp_result, rsp_id, rsp_zero);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_latency();
    step();
    req0_valid = 1'b1; req0_a = 5; req0_b = 7; req0_ctl = 3'b000; rsp_ready = 1'b1;
    #1;
    total++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      bad++; $display("FAIL lat_grant got=%b%b want=10", req0_ready, req1_ready);
    end
    step();
    req0_valid = 1'b0;
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++; $display("FAIL lat_t1 rsp_valid got=%b want=0", rsp_valid);
    end
    step();
    total++;
    if ({rsp_valid, rsp_result, rsp_id, rsp_zero} !== {1'b1, 32'd12, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL lat_t2 got v=%b r=%0d id=%b z=%b want v=1 r=12 id=0 z=0",
               rsp_valid, rsp_result, rsp_id, rsp_zero);
    end
    step();
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++; $display("FAIL lat_t3 rsp_valid got=%b want=0", rsp_valid);
    end
  endtask

  typedef struct {
    bit          id;
    logic [31:0] a, b;
    logic [2:0]  ctl;
    logic [31:0] exp;
  } vec_t;

  task automatic test_alu();
    vec_t v[12];
    bit g, s, z, rid;
    logic [31:0] r;
    v[0]  = '{1'b1, 32'd9,        32'd9,  3'b001, 32'd0};
    v[1]  = '{1'b1, 32'hFFFFFFFF, 32'd1,  3'b101, 32'd1};
    v[2]  = '{1'b1, 32'h80000000, 32'd1,  3'b101, 32'd1};
    v[3]  = '{1'b0, 32'd2,        32'd1,  3'b101, 32'd0};
    v[4]  = '{1'b0, 32'd3,        32'd4,  3'b110, 32'd0};
    v[5]  = '{1'b0, 32'h0000F0F0, 32'h0000FF00, 3'b010, 32'h0000F000};
    v[6]  = '{1'b1, 32'h0000F0F0, 32'h0000FF00, 3'b011, 32'h0000FFF0};
    v[7]  = '{1'b0, 32'hFFFFFFFF, 32'd2,  3'b000, 32'd1};
    v[8]  = '{1'b1, 32'd3,        32'd5,  3'b001, 32'hFFFFFFFE};
    v[9]  = '{1'b0, 32'd7,        32'd7,  3'b100, 32'd0};
    v[10] = '{1'b1, 32'd7,        32'd7,  3'b111, 32'd0};
    v[11] = '{1'b0, 32'h7FFFFFFF, 32'hFFFFFFFF, 3'b101, 32'd0};
    for (int i = 0; i < 12; i++) begin
      run_op(v[i].id, v[i].a, v[i].b, v[i].ctl, g, s, r, z, rid);
      total++;
      if (!g || !s || r !== v[i].exp || z !== (v[i].exp == 0) || rid !== v[i].id) begin
        bad++;
        $display("FAIL alu_vec%0d got g=%b s=%b r=%h z=%b id=%b want g=1 s=1 r=%h z=%b id=%b",
                 i, g, s, r, z, rid, v[i].exp, (v[i].exp == 0), v[i].id);
      end
    end
  endtask

  task automatic test_arbitration();
    bit grants[4];
    bit exp[4];
    int n = 0;
`ifdef ALU_ARB_RR_EN
    exp = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    do_reset();
    req0_valid = 1'b1; req0_a = 1; req0_b = 1; req0_ctl = 0;
    req1_valid = 1'b1; req1_a = 2; req1_b = 2; req1_ctl = 0;
    rsp_ready  = 1'b1;
    for (int c = 0; c < 40 && n < 4; c++) begin
      step();
      total++;
      if (req0_ready && req1_ready) begin
        bad++; $display("FAIL arb_onehot got=11 want at most one");
      end
      if (req0_ready) begin grants[n] = 1'b0; n++; end
      else if (req1_ready) begin grants[n] = 1'b1; n++; end
    end
    total++;
    if (n != 4) begin
      bad++; $display("FAIL arb_timeout grants got=%0d want=4", n);
    end
    for (int i = 0; i < n; i++) begin
      total++;
      if (grants[i] !== exp[i]) begin
        bad++; $display("FAIL arb_grant%0d got=%b want=%b", i, grants[i], exp[i]);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      total++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        bad++; $display("FAIL arb_novalid got=%b%b want=00", req0_ready, req1_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    step();
    req0_valid = 1'b1; req0_a = 1; req0_b = 2; req0_ctl = 3'b000; rsp_ready = 1'b0;
    step();
    req0_valid = 1'b0;
    step();
    req0_valid = 1'b1; req1_valid = 1'b1; req1_ctl = 3'b001; req1_b = 1;
    for (int i = 0; i < 5; i++) begin
      req1_a = 32'(i * 17);
      #1;
      total++;
      if ({rsp_valid, rsp_result, rsp_id, rsp_zero, req0_ready, req1_ready} !==
          {1'b1, 32'd3, 1'b0, 1'b0, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL bp_hold%0d got v=%b r=%0d id=%b z=%b rdy=%b%b want v=1 r=3 id=0 z=0 rdy=00",
                 i, rsp_valid, rsp_result, rsp_id, rsp_zero, req0_ready, req1_ready);
      end
      step();
    end
    req0_valid = 1'b0; req1_a = 100; rsp_ready = 1'b1;
    step();
    total++;
    if (rsp_valid !== 1'b0 || req1_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release got v=%b rdy1=%b want v=0 rdy1=1", rsp_valid, req1_ready);
    end
    step();
    req1_valid = 1'b0; req1_a = 555;
    step();
    total++;
    if (rsp_valid !== 1'b1 || rsp_result !== 32'd99 || rsp_id !== 1'b1) begin
      bad++;
      $display("FAIL bp_sample got v=%b r=%0d id=%b want v=1 r=99 id=1",
               rsp_valid, rsp_result, rsp_id);
    end
  endtask

  task automatic test_reset_exec();
    step();
    req0_valid = 1'b1; req0_a = 10; req0_b = 20; req0_ctl = 3'b000; rsp_ready = 1'b1;
    step();
    req0_valid = 1'b0; reset = 1'b1;
    step();
    total++;
    if ({rsp_valid, rsp_result, rsp_zero} !== {1'b0, 32'd0, 1'b1}) begin
      bad++;
      $display("FAIL rst_exec got v=%b r=%0d z=%b want v=0 r=0 z=1",
               rsp_valid, rsp_result, rsp_zero);
    end
    reset = 1'b0;
    req0_valid = 1'b1; req0_a = 4; req0_b = 6;
    req1_valid = 1'b1; req1_a = 50; req1_b = 50; req1_ctl = 3'b000;
    #1;
    total++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      bad++; $display("FAIL rst_first_grant got=%b%b want=10", req0_ready, req1_ready);
    end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    total++;
    if (rsp_valid !== 1'b1 || rsp_result !== 32'd10 || rsp_id !== 1'b0) begin
      bad++;
      $display("FAIL rst_after got v=%b r=%0d id=%b want v=1 r=10 id=0",
               rsp_valid, rsp_result, rsp_id);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_alu();
    test_arbitration();
    test_backpressure();
    test_reset_exec();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
